// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared types and helpers for the capture buffer read and write engines
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } cap_state_t;

    function automatic int capture_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/ring_addr_counter.sv
// rtl/ring_addr_counter.sv - loadable, enabled ring address counter that wraps at 2^ADDR_WIDTH
module ring_addr_counter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_value,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] value
);

    // Load wins over increment; the top of the range rolls over to zero naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/capture_readout.sv
// rtl/capture_readout.sv - streams a wrapped window of the capture RAM out over valid/ready
module capture_readout
    import capture_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] REM_FULL = (ADDR_WIDTH+1)'(capture_depth(ADDR_WIDTH));

    cap_state_t          state, next_state;
    logic [ADDR_WIDTH:0] remaining;
    logic                cnt_load, cnt_inc, load_sample, finish;

    ring_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (start_addr),
        .inc        (cnt_inc),
        .value      (ram_addr)
    );

    assign ram_cs = busy;
    assign ram_oe = busy;

    always_comb begin
        next_state  = state;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        load_sample = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_load   = 1'b1;
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (remaining == '0) begin
                    next_state = DRAIN;
                end else if (!m_valid || m_ready) begin
                    load_sample = 1'b1;
                    cnt_inc     = 1'b1;
                    if (remaining == REM_ONE) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // Abort overrides every action, including a start presented alongside it.
        if (abort) begin
            next_state  = IDLE;
            cnt_load    = 1'b0;
            cnt_inc     = 1'b0;
            load_sample = 1'b0;
            finish      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= next_state;
            done  <= finish;
            if (cnt_load) begin
                remaining <= (count == '0) ? REM_FULL : count;
                busy      <= 1'b1;
            end
            if (load_sample) begin
                m_data    <= ram_data;
                m_valid   <= 1'b1;
                m_last    <= (remaining == REM_ONE);
                remaining <= remaining - REM_ONE;
            end
            if (finish || abort) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                busy    <= 1'b0;
            end
        end
    end

endmodule

// File: doc/capture_readout.md
# capture_readout

Read-side engine for the oscilloscope capture buffer: on a start pulse it walks the single-port sample RAM from a given start address, wrapping modulo depth, and streams the requested number of samples out over a valid/ready interface toward the host link. It drives the RAM's read address, chip select and output enable. Its async-read data port is sampled into a registered output stage. Throughput is one sample per cycle while the consumer is ready.

## Interface
Parameters:
- DATA_WIDTH, 8: sample width, equal to the RAM data width.
- ADDR_WIDTH, 8: RAM address width; depth is 2^ADDR_WIDTH.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- start_addr  in  ADDR_WIDTH  first address read; sampled with start.
- count  in  ADDR_WIDTH+1  number of samples; 0 is treated as 2^ADDR_WIDTH; sampled with start.
- abort  in  1  terminates a transfer; dominates everything except rst.
- ram_addr  out  ADDR_WIDTH  RAM read address.
- ram_cs, ram_oe  out  1 each  high exactly while busy.
- ram_data  in  DATA_WIDTH  RAM async read data.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_last  out  1  qualifies the final sample; meaningful only with m_valid.
- m_ready  in  1  consumer ready.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after the last handshake.

## Operation
- States: IDLE, STREAM, DRAIN.
- **IDLE**
  - start=1: latch start_addr into ram_addr and count into remaining.
  - Go to STREAM; busy, ram_cs and ram_oe rise the next cycle.
- **STREAM**
  - The output register loads ram_data when it is empty or being consumed (m_valid=0 or m_ready=1) and remaining>0.
  - On that load: m_valid<=1, ram_addr<=ram_addr+1 (natural wrap 2^ADDR_WIDTH-1 → 0), remaining<=remaining-1.
  - m_last is set together with the load that takes remaining from 1 to 0.
  - Once remaining reaches 0, go to DRAIN.
- **DRAIN**
  - Hold m_data, m_valid and m_last until m_ready.
  - On that handshake: m_valid<=0, m_last<=0, busy/ram_cs/ram_oe<=0, done<=1 for one cycle, then IDLE.
- m_data, m_last: stable while m_valid=1 and m_ready=0 (AXI-stream rule).
- start while busy: ignored; the running transfer continues unaffected.
- abort in any state: next cycle m_valid=0, m_last=0, busy=0, ram_cs=ram_oe=0, go to IDLE.
  - No done pulse.
  - A start in the same cycle as abort is ignored.
- Widths: remaining is ADDR_WIDTH+1 bits; count=0 loads 2^ADDR_WIDTH. The address counter is exactly ADDR_WIDTH bits and wraps silently.
- Reset values (async, immediate): state IDLE, ram_addr=0, ram_cs=0, ram_oe=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0, remaining=0.
- Reset mid-transfer: same values, no done pulse.

## Timing
- Start accepted at edge N: busy=1 and ram_addr=start_addr after N.
- First m_valid=1 with m_data=mem[start_addr] after edge N+1.
- With m_ready held high, one sample per cycle. A count-K transfer shows m_valid on edges N+1..N+K and done after edge N+K+1.
- The RAM is combinational on the read path: ram_addr changes at an edge and ram_data settles within the same cycle. No extra wait state.
- Back-to-back: a new start is accepted in the cycle done is high (state is IDLE then).
- A RAM write to the address currently presented shows its new value one cycle later. Coherency is the capture side's responsibility; this block does not guard against it.

## Structure
- Shared package capture_pkg holds:
  - the state enum (IDLE, STREAM, DRAIN);
  - the depth localparam helper (depth = 1 << ADDR_WIDTH), also used by the capture write-side controller.
- One natural sub-module, ring_addr_counter: ADDR_WIDTH-bit loadable, enabled, wrapping counter (load, load_value, inc, value). It is reused by the write-side controller.
- Everything else lives in the top module.

## Test plan
- RAM preloaded mem[i]=i. start_addr=0x10, count=4, m_ready=1 → m_data 0x10,0x11,0x12,0x13 on four consecutive cycles; m_last on 0x13; done one cycle later.
- Wrap: start_addr=0xFE, count=4 → 0xFE,0xFF,0x00,0x01; ram_addr returns through 0.
- count=0 → 256 samples starting at start_addr; exactly one m_last, on the 256th sample, which is mem[start_addr-1].
- Backpressure: m_ready toggles randomly → m_data/m_last held stable while stalled; all samples delivered in order with no duplicates or drops.
- abort during stall after 2 of 8 samples → next cycle m_valid=0, busy=0, ram_oe=0, no done. An immediate new start (0x40, 2) delivers 0x40,0x41.
- rst asserted mid-transfer while m_valid=1 → all outputs 0 immediately; start ignored while busy (checked in a separate run).
